// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point helpers for the CNN datapath stages:
// saturation bounds, accumulator sizing and a shift-and-saturate function.
package cnn_fixed_pkg;

    localparam int ACC_W = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        COEF_WEIGHT,
        COEF_BIAS
    } coef_slot_e;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a K*K dot product of W-bit signed operands plus bias,
    // large enough that no partial sum can overflow.
    function automatic int sum_width(input int w, input int k);
        return 2 * w + $clog2(k * k) + 1;
    endfunction

    function automatic acc_t sat_max(input int w);
        return (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    endfunction

    function automatic acc_t sat_min(input int w);
        return -(acc_t'(1) <<< (w - 1));
    endfunction

    // Arithmetic shift (floor) then clamp into the signed w-bit range.
    function automatic acc_t shift_saturate(
        input acc_t acc,
        input int   frac,
        input int   w
    );
        acc_t s;
        s = acc >>> frac;
        if (s > sat_max(w)) begin
            s = sat_max(w);
        end else if (s < sat_min(w)) begin
            s = sat_min(w);
        end
        return s;
    endfunction

endpackage

// File: rtl/window_pos_tracker.sv
// Tracks the image position of each incoming KxK window.
// Ports: clock, sreset_n, advance (window seen), legal (no row wrap),
// frame_last (last window of frame), out_row/out_col (output-map coords).
module window_pos_tracker
    import cnn_fixed_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5
) (
    input  logic                           clock,
    input  logic                           sreset_n,
    input  logic                           advance,
    output logic                           legal,
    output logic                           frame_last,
    output logic [$clog2(COLUMN_SIZE)-1:0] out_row,
    output logic [$clog2(ROW_SIZE)-1:0]    out_col
);

    localparam int ROW_W = $clog2(COLUMN_SIZE);
    localparam int COL_W = $clog2(ROW_SIZE);
    // The first full window ends at (K-1, K-1); everything before it
    // is line-buffer fill and produces no window.
    localparam int NWIN  = ROW_SIZE * COLUMN_SIZE
                         - (ROW_SIZE * (KERNEL_SIZE - 1) + KERNEL_SIZE - 1);
    localparam int WIN_W = clog2_min1(NWIN);

    localparam logic [COL_W-1:0] COL_START = COL_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(COLUMN_SIZE - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(NWIN - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIN_W-1:0] wincnt;

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            col    <= COL_START;
            row    <= ROW_START;
            wincnt <= '0;
        end else if (advance) begin
            if (wincnt == WIN_LAST) begin
                col    <= COL_START;
                row    <= ROW_START;
                wincnt <= '0;
            end else begin
                wincnt <= wincnt + WIN_W'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Windows whose right edge sits in columns 0..K-2 straddle a wrap.
    assign legal      = (col >= COL_START);
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);
    assign out_row    = row - ROW_START;
    assign out_col    = col - COL_START;

endmodule

// File: rtl/conv_window_mac.sv
// KxK fixed-point convolution MAC behind the line-buffer window generator.
// Ports: clock, sreset_n; weight_valid/weight_in load K*K weights then bias,
// weights_ready flags a full set; window_valid/window_in carry flattened
// windows; out_valid/data_out/out_row/out_col/frame_done give results,
// 3 cycles after the window. Optional macro CONV_WINDOW_MAC_RELU_EN clamps
// negative results to 0.
module conv_window_mac
    import cnn_fixed_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5
) (
    input  logic                                      clock,
    input  logic                                      sreset_n,
    input  logic                                      weight_valid,
    input  logic [DATA_WIDTH-1:0]                     weight_in,
    output logic                                      weights_ready,
    input  logic                                      window_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_in,
    output logic                                      out_valid,
    output logic signed [DATA_WIDTH-1:0]              data_out,
    output logic [$clog2(COLUMN_SIZE)-1:0]            out_row,
    output logic [$clog2(ROW_SIZE)-1:0]               out_col,
    output logic                                      frame_done
);

    localparam int NE    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int W     = DATA_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int SUM_W = sum_width(DATA_WIDTH, KERNEL_SIZE);
    localparam int WC_W  = clog2_min1(NE + 1);
    localparam int ROW_W = $clog2(COLUMN_SIZE);
    localparam int COL_W = $clog2(ROW_SIZE);

    localparam logic [WC_W-1:0] BIAS_SLOT = WC_W'(NE);

    logic [WC_W-1:0]       wcnt;
    logic signed [W-1:0]   weights [NE];
    logic signed [W-1:0]   bias;
    coef_slot_e            slot;

    logic                  legal;
    logic                  last;
    logic [ROW_W-1:0]      pos_row;
    logic [COL_W-1:0]      pos_col;
    logic                  accept;

    logic signed [PW-1:0]  prod_next [NE];
    logic signed [PW-1:0]  s1_prod [NE];
    logic signed [W-1:0]   s1_bias;
    logic                  s1_valid;
    logic                  s1_last;
    logic [ROW_W-1:0]      s1_row;
    logic [COL_W-1:0]      s1_col;

    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] s2_sum;
    logic                    s2_valid;
    logic                    s2_last;
    logic [ROW_W-1:0]        s2_row;
    logic [COL_W-1:0]        s2_col;

    acc_t                  sat;
    logic signed [W-1:0]   result;

    assign slot = (wcnt == BIAS_SLOT) ? COEF_BIAS : COEF_WEIGHT;

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            wcnt          <= '0;
            weights_ready <= 1'b0;
            bias          <= '0;
            for (int e = 0; e < NE; e++) begin
                weights[e] <= '0;
            end
        end else if (weight_valid) begin
            unique case (slot)
                COEF_BIAS: begin
                    bias          <= weight_in;
                    wcnt          <= '0;
                    weights_ready <= 1'b1;
                end
                COEF_WEIGHT: begin
                    weights[wcnt] <= weight_in;
                    wcnt          <= wcnt + WC_W'(1);
                    if (wcnt == '0) begin
                        weights_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    window_pos_tracker #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ROW_SIZE    (ROW_SIZE),
        .COLUMN_SIZE (COLUMN_SIZE)
    ) u_pos (
        .clock      (clock),
        .sreset_n   (sreset_n),
        .advance    (window_valid),
        .legal      (legal),
        .frame_last (last),
        .out_row    (pos_row),
        .out_col    (pos_col)
    );

    // Registered coefficients are read here, so a coincident write only
    // affects later windows.
    assign accept = window_valid && legal && weights_ready;

    always_comb begin
        for (int e = 0; e < NE; e++) begin
            prod_next[e] = PW'($signed(window_in[e*W +: W]))
                         * PW'(weights[e]);
        end
    end

    always_comb begin
        sum_next = SUM_W'(s1_bias) <<< FRAC_BITS;
        for (int e = 0; e < NE; e++) begin
            sum_next = sum_next + SUM_W'(s1_prod[e]);
        end
    end

    always_comb begin
        sat = shift_saturate(ACC_W'(s2_sum), FRAC_BITS, DATA_WIDTH);
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (sat < 0) begin
            sat = '0;
        end
`endif
        result = sat[W-1:0];
    end

    // Bias travels with S1 so a mid-flight reload cannot mix coefficient sets.
    always_ff @(posedge clock) begin
        s1_prod <= prod_next;
        s1_bias <= bias;
        s1_last <= last;
        s1_row  <= pos_row;
        s1_col  <= pos_col;
        s2_sum  <= sum_next;
        s2_last <= s1_last;
        s2_row  <= s1_row;
        s2_col  <= s1_col;
    end

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            s1_valid   <= accept;
            s2_valid   <= s1_valid;
            out_valid  <= s2_valid;
            data_out   <= s2_valid ? result : '0;
            out_row    <= s2_valid ? s2_row : '0;
            out_col    <= s2_valid ? s2_col : '0;
            frame_done <= s2_valid && s2_last;
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac against a position/arithmetic
// reference model driven by randomized windows and coefficient sets.
module tb_conv_window_mac;

    localparam int K    = 3;
    localparam int W    = 16;
    localparam int F    = 8;
    localparam int RS   = 5;
    localparam int CS   = 5;
    localparam int NE   = K * K;
    localparam int BASE = RS * (K - 1) + K - 1;
    localparam int NWIN = RS * CS - BASE;

    typedef struct packed {
        logic          wv;
        logic [W-1:0]  wi;
        logic          winv;
        logic [NE*W-1:0] win;
    } stim_t;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic [2:0]   r;
        logic [2:0]   c;
        logic         fd;
    } exp_t;

    logic            clock = 1'b0;
    logic            sreset_n;
    logic            weight_valid;
    logic [W-1:0]    weight_in;
    logic            weights_ready;
    logic            window_valid;
    logic [NE*W-1:0] window_in;
    logic            out_valid;
    logic [W-1:0]    data_out;
    logic [2:0]      out_row;
    logic [2:0]      out_col;
    logic            frame_done;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] m_w [NE];
    logic [W-1:0] m_bias;
    int           m_wcnt;
    bit           m_ready;
    int           m_n;
    exp_t         pipe [$];

    always #5 clock = ~clock;

    conv_window_mac dut (
        .clock         (clock),
        .sreset_n      (sreset_n),
        .weight_valid  (weight_valid),
        .weight_in     (weight_in),
        .weights_ready (weights_ready),
        .window_valid  (window_valid),
        .window_in     (window_in),
        .out_valid     (out_valid),
        .data_out      (data_out),
        .out_row       (out_row),
        .out_col       (out_col),
        .frame_done    (frame_done)
    );

    function automatic logic [W-1:0] conv_ref(input logic [NE*W-1:0] win);
        longint acc;
        acc = 0;
        for (int e = 0; e < NE; e++) begin
            acc += longint'($signed(win[e*W +: W])) * longint'($signed(m_w[e]));
        end
        acc += longint'($signed(m_bias)) * (longint'(1) << F);
        acc = acc >>> F;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[W-1:0];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t coef(input logic [W-1:0] v);
        stim_t s;
        s = '0;
        s.wv = 1'b1;
        s.wi = v;
        return s;
    endfunction

    function automatic stim_t win_fill(input logic [W-1:0] v);
        stim_t s;
        s = '0;
        s.winv = 1'b1;
        for (int e = 0; e < NE; e++) s.win[e*W +: W] = v;
        return s;
    endfunction

    function automatic stim_t win_rand(input int mag);
        stim_t s;
        int t;
        s = '0;
        s.winv = 1'b1;
        for (int e = 0; e < NE; e++) begin
            t = int'($urandom_range(0, 2 * mag - 1)) - mag;
            s.win[e*W +: W] = t[W-1:0];
        end
        return s;
    endfunction

    function automatic logic [W-1:0] rand_val(input int mag);
        int t;
        t = int'($urandom_range(0, 2 * mag - 1)) - mag;
        return t[W-1:0];
    endfunction

    function automatic string got_str();
        return $sformatf("v=%b d=%h rc=(%0d,%0d) fd=%b rdy=%b",
            out_valid, data_out, out_row, out_col, frame_done, weights_ready);
    endfunction

    function automatic string exp_str(input exp_t e);
        return $sformatf("v=%b d=%h rc=(%0d,%0d) fd=%b rdy=%b",
            e.v, e.d, e.r, e.c, e.fd, m_ready);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NE; e++) m_w[e] = '0;
        m_bias  = '0;
        m_wcnt  = 0;
        m_ready = 1'b0;
        m_n     = 0;
        pipe    = {};
        pipe.push_back('0);
        pipe.push_back('0);
    endtask

    // Apply one cycle of stimulus; returns the output expected now.
    task automatic step(input stim_t s, output exp_t e);
        exp_t nw;
        int pos, r, c;
        nw = '0;
        if (s.winv) begin
            pos = BASE + m_n;
            r = pos / RS;
            c = pos % RS;
            if (c >= K - 1 && m_ready) begin
                nw.v  = 1'b1;
                nw.d  = conv_ref(s.win);
                nw.r  = 3'(r - (K - 1));
                nw.c  = 3'(c - (K - 1));
                nw.fd = (r == CS - 1) && (c == RS - 1);
            end
            m_n = (m_n == NWIN - 1) ? 0 : m_n + 1;
        end
        if (s.wv) begin
            if (m_wcnt == NE) begin
                m_bias  = s.wi;
                m_ready = 1'b1;
                m_wcnt  = 0;
            end else begin
                if (m_wcnt == 0) m_ready = 1'b0;
                m_w[m_wcnt] = s.wi;
                m_wcnt++;
            end
        end
        weight_valid = s.wv;
        weight_in    = s.wi;
        window_valid = s.winv;
        window_in    = s.win;
        @(posedge clock);
        #1;
        pipe.push_back(nw);
        e = pipe.pop_front();
    endtask

    task automatic do_reset();
        sreset_n = 1'b0;
        @(posedge clock);
        #1;
        sreset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        sreset_n     = 1'b0;
        weight_valid = 1'b1;
        weight_in    = 16'h1234;
        window_valid = 1'b1;
        window_in    = '1;
        repeat (2) @(posedge clock);
        #1;
        weight_valid = 1'b0;
        window_valid = 1'b0;
        do_reset();
        nvec++;
        if (out_valid !== 1'b0 || data_out !== '0 || out_row !== '0 ||
            out_col !== '0 || frame_done !== 1'b0 || weights_ready !== 1'b0) begin
            nerr++;
            $display("FAIL reset: got %s, want all zero", got_str());
        end
    endtask

    task automatic test_basic();
        stim_t q[$];
        exp_t e;
        int npulse = 0;
        int nfd = 0;
        for (int i = 0; i < NE; i++) q.push_back(coef(16'h0100));
        q.push_back(coef(16'h0000));
        for (int i = 0; i < NWIN; i++) q.push_back(win_fill(16'h0100));
        repeat (3) q.push_back(idle());
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL basic step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
            if (out_valid === 1'b1) begin
                npulse++;
                nvec++;
                if (data_out !== 16'h0900) begin
                    nerr++;
                    $display("FAIL basic value: got %h, want 0900", data_out);
                end
            end
            if (frame_done === 1'b1) nfd++;
        end
        nvec++;
        if (npulse !== 9 || nfd !== 1) begin
            nerr++;
            $display("FAIL basic counts: got %0d pulses %0d frame_done, want 9 and 1",
                npulse, nfd);
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        exp_t e;
        for (int i = 0; i < NWIN; i++) q.push_back(win_rand(2048));
        for (int i = 0; i < NWIN; i++) q.push_back(win_rand(32768));
        repeat (3) q.push_back(idle());
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL back_to_back step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_saturation();
        stim_t q[$];
        exp_t e;
        logic [W-1:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            q = {};
            for (int i = 0; i < NE; i++) q.push_back(coef(pass == 0 ? 16'h7FFF : 16'h8000));
            q.push_back(coef(16'h0000));
            for (int i = 0; i < NWIN; i++) q.push_back(win_fill(16'h7FFF));
            repeat (3) q.push_back(idle());
            want = (pass == 0) ? 16'h7FFF : 16'h8000;
`ifdef CONV_WINDOW_MAC_RELU_EN
            if (pass == 1) want = 16'h0000;
`endif
            for (int i = 0; i < q.size(); i++) begin
                step(q[i], e);
                nvec++;
                if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                    (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                    nerr++;
                    $display("FAIL saturation step %0d: got %s, want %s", i, got_str(), exp_str(e));
                end
                if (out_valid === 1'b1 && data_out !== want) begin
                    nerr++;
                    $display("FAIL saturation value: got %h, want %h", data_out, want);
                end
            end
        end
    endtask

    task automatic test_mixed();
        stim_t q[$];
        stim_t s;
        exp_t e;
        for (int i = 0; i < NE; i++) q.push_back(coef(i == 4 ? 16'h0080 : 16'h0000));
        q.push_back(coef(16'hFF00));
        for (int i = 0; i < NWIN; i++) begin
            s = win_rand(32768);
            s.win[4*W +: W] = 16'h0400;
            q.push_back(s);
        end
        repeat (3) q.push_back(idle());
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL mixed step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
            if (out_valid === 1'b1 && data_out !== 16'h0100) begin
                nerr++;
                $display("FAIL mixed value: got %h, want 0100", data_out);
            end
        end
    endtask

    task automatic test_reload();
        stim_t q[$];
        stim_t s;
        exp_t e;
        for (int i = 0; i < 4; i++) q.push_back(win_rand(4096));
        for (int i = 0; i <= NE; i++) begin
            s = win_rand(4096);
            s.wv = 1'b1;
            s.wi = (i == NE) ? rand_val(4096) : rand_val(512);
            q.push_back(s);
        end
        for (int i = 0; i < 12; i++) begin
            s = ($urandom_range(0, 3) == 0) ? idle() : win_rand(4096);
            q.push_back(s);
        end
        repeat (3) q.push_back(idle());
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL reload step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        exp_t e;
        int nseen = 0;
        for (int i = 0; i < NE; i++) q.push_back(coef(rand_val(1024)));
        q.push_back(coef(rand_val(1024)));
        while (m_n != 0) begin
            step(win_rand(1024), e);
        end
        for (int i = 0; i < 7; i++) q.push_back(win_rand(1024));
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL reset_mid pre step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
        end
        weight_valid = 1'b0;
        window_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0 || weights_ready !== 1'b0) begin
                nerr++;
                $display("FAIL reset_mid drain %0d: got %s, want idle", i, got_str());
            end
            step(idle(), e);
        end
        q = {};
        for (int i = 0; i <= NE; i++) q.push_back(coef(rand_val(1024)));
        for (int i = 0; i < NWIN; i++) q.push_back(win_rand(8192));
        repeat (3) q.push_back(idle());
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], e);
            nvec++;
            if (out_valid !== e.v || frame_done !== e.fd || weights_ready !== m_ready ||
                (e.v && (data_out !== e.d || out_row !== e.r || out_col !== e.c))) begin
                nerr++;
                $display("FAIL reset_mid post step %0d: got %s, want %s", i, got_str(), exp_str(e));
            end
            if (out_valid === 1'b1 && nseen++ == 0) begin
                nvec++;
                if (out_row !== 3'd0 || out_col !== 3'd0) begin
                    nerr++;
                    $display("FAIL reset_mid first coord: got (%0d,%0d), want (0,0)",
                        out_row, out_col);
                end
            end
        end
    endtask

    initial begin
        sreset_n     = 1'b0;
        weight_valid = 1'b0;
        weight_in    = '0;
        window_valid = 1'b0;
        window_in    = '0;
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_mixed();
        test_reload();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream stage of the line-buffer image window generator.
- Consumes each flattened KERNEL_SIZE×KERNEL_SIZE window and its valid strobe.
- Discards windows that straddle a row wrap, convolves the remaining windows with a loaded signed fixed-point kernel plus bias, and emits one saturated pixel per legal window, tagged with its output row/column.
- Pipelined at one window per clock.

Parameters:
- KERNEL_SIZE, 3, kernel edge length.
- DATA_WIDTH, 16, signed pixel/weight/bias width.
- FRAC_BITS, 8, fractional bits of all fixed-point operands and the result.
- ROW_SIZE, 5, pixels per image row.
- COLUMN_SIZE, 5, rows per image.

Ports:
- clock  in  1  clock; all logic on the rising edge.
- sreset_n  in  1  synchronous, active-low reset.
- weight_valid  in  1  weight_in is a valid coefficient this cycle.
- weight_in  in  DATA_WIDTH  coefficient stream: KERNEL_SIZE² weights (element 0 first), then bias.
- weights_ready  out  1  full coefficient set loaded.
- window_valid  in  1  window_in valid (upstream out_valid).
- window_in  in  KERNEL_SIZE²·DATA_WIDTH  element e=r·K+c at bits [(e+1)·W−1 : e·W].
- out_valid  out  1  data_out/out_row/out_col valid.
- data_out  out  DATA_WIDTH  signed saturated convolution result.
- out_row  out  $clog2(COLUMN_SIZE)  output-map row of data_out.
- out_col  out  $clog2(ROW_SIZE)  output-map column of data_out.
- frame_done  out  1  one-cycle pulse with the last output pixel of a frame.

Behaviour:
- Reset (sreset_n=0 at an edge): all outputs 0. Coefficient counter, column/row/window counters and pipeline valids clear. Weight registers and bias are also cleared. Reset mid-frame or mid-load abandons it; in-flight results are dropped.
- Coefficient load:
  - Each weight_valid writes weight_in into slot wcnt (0..K²−1 = weights, K² = bias), then wcnt increments.
  - The first write of a set (wcnt=0) drops weights_ready that cycle.
  - The write of the bias sets weights_ready=1 and returns wcnt to 0.
  - Writes take effect on the next edge.
- Window tracking (advances on every window_valid, regardless of weights_ready):
  - col starts at K−1 and wraps ROW_SIZE−1→0.
  - row starts at K−1 and increments when col wraps.
  - wincnt counts 0..ROW_SIZE·COLUMN_SIZE−(ROW_SIZE·(K−1)+K−1)−1, then clears col, row and wincnt to their start values (frame boundary).
  - A window is legal iff col ≥ K−1.
  - Output coordinates: out_row = row−(K−1), out_col = col−(K−1).
- Accept condition: window_valid ∧ legal ∧ weights_ready. Only accepted windows enter the pipeline as valid.
- Pipeline, fixed latency 3, fully pipelined, no stall:
  - S1 registers the K² signed products (2W bits).
  - S2 registers the sum of the products plus (bias <<< FRAC_BITS). Sum width is 2W+$clog2(K²)+1; no intermediate overflow.
  - S3 arithmetic-shifts right by FRAC_BITS (truncate toward −∞) and saturates to [−2^(W−1), 2^(W−1)−1].
- Coordinates and the frame-last flag travel alongside the data through the pipeline.
- frame_done asserts with out_valid for out_row=COLUMN_SIZE−K and out_col=ROW_SIZE−K.
- Illegal windows, or windows arriving while weights_ready=0, produce no output but still advance the counters.
- Simultaneous coefficient write and window: the window uses the pre-write coefficients.

Optional Feature:
- Macro CONV_WINDOW_MAC_RELU_EN.
- When defined: S3 forces a negative saturated result to 0, so data_out ≥ 0.
- When undefined: signed result passes unchanged.
- Latency is 3 in both cases.

Decomposition:
- Shared package cnn_fixed_pkg:
  - saturation bounds per DATA_WIDTH;
  - the sum-width expression;
  - a saturate/round function reused by later layers.
- One natural sub-module, window_pos_tracker: col/row/wincnt counters, legality flag, frame-last flag. Reusable by pooling stages.
- The MAC pipeline stays in the top level.

Test Plan:
- All defaults. Load weights all 0x0100 and bias 0x0000; stream 13 windows of all 0x0100 → weights_ready=1 after the 10th write. Exactly 9 out_valid pulses with data_out=0x0900, (out_row,out_col) = (0,0),(0,1),(0,2),(1,0)…(2,2), each 3 cycles after its window. frame_done only on (2,2).
- Row-wrap check: window valid on every cycle for 13 cycles → no output for the 4th, 5th, 9th and 10th windows (col 0,1). A second frame immediately after restarts at (0,0).
- Saturation: weights 0x7FFF and window 0x7FFF → 0x7FFF. Weights 0x8000 with window 0x7FFF → 0x8000, or 0x0000 with CONV_WINDOW_MAC_RELU_EN defined.
- Mixed signs: weights 0x0080 (0.5) on element 4, others 0, bias 0xFF00 (−1.0); centre pixel 0x0400 → data_out=0x0100.
- Reload: start a new coefficient set mid-frame → weights_ready falls on the first write and those windows yield no output. Outputs resume with the new weights after the bias write; coordinates stay consistent.
- Reset mid-frame with 2 results in flight → no out_valid after reset. Coefficients cleared (weights_ready=0). The next frame after reload starts at (0,0).
